// File: rtl/uart_tx_arbiter_if.sv
// uart_tx_arbiter_if
//   Bundles the requester-side, transmitter-side and baud-controller-side
//   signals of the shared UART transmit arbiter.
//   master : arbiter view (drives grant/tx_wr/tx_data/baud_select/status)
//   slave  : environment view (requesters, transmitter, baud controller)
//   Signals:
//     req[3:0]        per-requester request, held until granted
//     req_data[31:0]  byte for requester i at [8i+7:8i]
//     req_baud[11:0]  baud code for requester i at [3i+2:3i]
//     grant[3:0]      one-hot acceptance pulse
//     tx_wr, tx_data  transmitter write strobe and byte
//     tx_busy         transmitter frame-in-flight flag
//     baud_select     baud code to the baud controller
//     sample_enable   tick from the baud controller
//     owner, active, err_timeout  status
interface uart_tx_arbiter_if;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic [11:0] req_baud;
  logic [3:0]  grant;
  logic        tx_wr;
  logic [7:0]  tx_data;
  logic        tx_busy;
  logic [2:0]  baud_select;
  logic        sample_enable;
  logic [1:0]  owner;
  logic        active;
  logic        err_timeout;

  modport master (
    input  req, req_data, req_baud, tx_busy, sample_enable,
    output grant, tx_wr, tx_data, baud_select, owner, active, err_timeout
  );

  modport slave (
    output req, req_data, req_baud, tx_busy, sample_enable,
    input  grant, tx_wr, tx_data, baud_select, owner, active, err_timeout
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//   Shares one UART transmitter and its baud controller among four byte
//   requesters using round-robin arbitration. The baud code is changed only
//   between frames and the baud tick is allowed to settle before the frame is
//   launched; the transmitter busy/done handshake is then tracked, followed by
//   an idle-line gap.
//   Ports:
//     clk    system clock, posedge
//     reset  asynchronous, active-low
//     bus    uart_tx_arbiter_if.master (see interface header for signals)
module uart_tx_arbiter #(
  parameter logic [2:0] DEFAULT_BAUD = 3'b111,
  parameter int         SETTLE_TICKS = 2,
  parameter int         GAP_TICKS    = 16,
  parameter int         TIMEOUT      = 1023
) (
  input  logic                   clk,
  input  logic                   reset,
  uart_tx_arbiter_if.master      bus
);

  typedef enum logic [2:0] {
    IDLE, CFG, SETTLE, LAUNCH, WAIT_BUSY, WAIT_DONE, GAP
  } state_t;

  // Terminal counts; counters run from 0 (settle/gap) or 1 (timeout).
  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_TICKS - 1);
  localparam logic [7:0] GAP_LAST    = 8'(GAP_TICKS - 1);
  localparam logic [9:0] TMO_LAST    = 10'(TIMEOUT - 1);

  state_t      state;
  logic [1:0]  ptr;
  logic [3:0]  settle_cnt;
  logic [7:0]  gap_cnt;
  logic [9:0]  tmo_cnt;

  logic [3:0]  grant_q;
  logic        tx_wr_q;
  logic [7:0]  tx_data_q;
  logic [2:0]  baud_q;
  logic [1:0]  owner_q;
  logic        active_q;
  logic        err_q;

  logic        own_req;
  logic [2:0]  own_baud;
  logic [7:0]  own_data;

  assign own_req  = bus.req[owner_q];
  assign own_baud = bus.req_baud[3*owner_q +: 3];
  assign own_data = bus.req_data[8*owner_q +: 8];

  assign bus.grant       = grant_q;
  assign bus.tx_wr       = tx_wr_q;
  assign bus.tx_data     = tx_data_q;
  assign bus.baud_select = baud_q;
  assign bus.owner       = owner_q;
  assign bus.active      = active_q;
  assign bus.err_timeout = err_q;

  // First set request scanning p, p+1, ... modulo 4.
  function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] p);
    logic [1:0] idx;
    logic       found;
    rr_pick = p;
    found   = 1'b0;
    for (int i = 0; i < 4; i++) begin
      idx = p + 2'(i);
      if (!found && r[idx]) begin
        rr_pick = idx;
        found   = 1'b1;
      end
    end
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      ptr        <= 2'd0;
      settle_cnt <= '0;
      gap_cnt    <= '0;
      tmo_cnt    <= '0;
      grant_q    <= '0;
      tx_wr_q    <= 1'b0;
      tx_data_q  <= '0;
      baud_q     <= DEFAULT_BAUD;
      owner_q    <= 2'd0;
      active_q   <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      // Strobes are single-cycle unless re-asserted below.
      grant_q <= '0;
      tx_wr_q <= 1'b0;
      err_q   <= 1'b0;
      case (state)
        IDLE: begin
          if (|bus.req) begin
            owner_q  <= rr_pick(bus.req, ptr);
            active_q <= 1'b1;
            state    <= CFG;
          end
        end
        CFG: begin
          if (!own_req) begin
            active_q <= 1'b0;
            state    <= IDLE;
          end else if (own_baud == baud_q) begin
            // Strobes are set on entry so they are high during LAUNCH.
            tx_wr_q   <= 1'b1;
            tx_data_q <= own_data;
            grant_q   <= 4'b0001 << owner_q;
            state     <= LAUNCH;
          end else begin
            baud_q     <= own_baud;
            settle_cnt <= '0;
            state      <= SETTLE;
          end
        end
        SETTLE: begin
          if (bus.sample_enable) begin
            if (settle_cnt == SETTLE_LAST) begin
              tx_wr_q   <= 1'b1;
              tx_data_q <= own_data;
              grant_q   <= 4'b0001 << owner_q;
              state     <= LAUNCH;
            end else begin
              settle_cnt <= settle_cnt + 4'd1;
            end
          end
        end
        LAUNCH: begin
          ptr     <= owner_q + 2'd1;
          // The LAUNCH cycle itself is cycle 1 of the busy-rise window.
          tmo_cnt <= 10'd1;
          state   <= WAIT_BUSY;
        end
        WAIT_BUSY: begin
          if (bus.tx_busy) begin
            state <= WAIT_DONE;
          end else if (tmo_cnt == TMO_LAST) begin
            err_q    <= 1'b1;
            active_q <= 1'b0;
            state    <= IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + 10'd1;
          end
        end
        WAIT_DONE: begin
          if (!bus.tx_busy) begin
            if (GAP_TICKS == 0) begin
              active_q <= 1'b0;
              state    <= IDLE;
            end else begin
              gap_cnt <= '0;
              state   <= GAP;
            end
          end
        end
        GAP: begin
          if (bus.sample_enable) begin
            if (gap_cnt == GAP_LAST) begin
              active_q <= 1'b0;
              state    <= IDLE;
            end else begin
              gap_cnt <= gap_cnt + 8'd1;
            end
          end
        end
        default: begin
          active_q <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule
